mem_cl_responder: RTL
=====================

Name: mem_cl_responder

Overview:
- Memory-side responder for the core's cache-line memory port; it sits opposite the L1D/L1I arbiter on the same port.
- It accepts one outstanding cache-line load or store and services it from an on-chip backing array after a programmable latency.
- It returns a single-cycle response carrying load data.
- Used as the FPGA/sim memory endpoint behind the core wrapper.

Parameters:
- ADDR_W, 32: request address width (matches M_WIDTH).
- LG_CL_BYTES, 4: log2 of the cache-line size in bytes. Line width CL_BITS = 8<<LG_CL_BYTES = 128.
- LG_DEPTH, 10: log2 of the number of lines in the backing array.
- LATENCY, 4: cycles from request capture to response pulse. Minimum 1.
- OPC_LOAD, 4'd4: opcode for a cache-line read.
- OPC_STORE, 4'd7: opcode for a cache-line write.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- mem_req_valid  in  1  request pending; held high until the response cycle
- mem_req_addr  in  ADDR_W  byte address of the line
- mem_req_store_data  in  CL_BITS  line data for stores
- mem_req_opcode  in  4  OPC_LOAD or OPC_STORE
- mem_rsp_valid  out  1  one-cycle response pulse
- mem_rsp_load_data  out  CL_BITS  line data; valid when mem_rsp_valid is high
- busy  out  1  a request is captured and not yet responded
- bad_opcode  out  1  sticky flag, set on an unknown opcode
- load_count  out  32  number of loads completed
- store_count  out  32  number of stores completed

Behaviour:
- Reset (async, active-high) clears the following:
  - state goes to IDLE;
  - mem_rsp_valid=0, mem_rsp_load_data=0, busy=0, bad_opcode=0, load_count=0, store_count=0;
  - the latency counter goes to 0.
- The backing array is not reset.
- Reset asserted mid-request drops that request: no response is issued and no array write occurs.

State machine: IDLE, ARM, WAIT, RESP.
- IDLE:
  - If mem_req_valid=1, go to ARM.
  - Fields are not sampled in IDLE: the requester's address/opcode mux settles only one cycle after valid rises.
- ARM:
  - If mem_req_valid is still 1, capture addr, opcode and store_data.
  - Load counter = LATENCY-1, set busy=1, go to WAIT.
  - If mem_req_valid=0, return to IDLE with nothing captured.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter equals 0, perform the access and go to RESP.
  - Inputs are ignored while in WAIT.
- Access rules:
  - index = captured addr[LG_CL_BYTES +: LG_DEPTH].
  - Upper address bits are ignored, so addresses alias modulo the array size.
  - Low LG_CL_BYTES address bits are ignored.
  - Load: mem_rsp_load_data <= array[index].
  - Store: array[index] <= captured store_data; mem_rsp_load_data <= captured store_data (write-through echo).
  - Unknown opcode: no array write, mem_rsp_load_data <= 0, bad_opcode <= 1.
- RESP:
  - mem_rsp_valid=1 for exactly one cycle.
  - Increment load_count or store_count; counters wrap at 2^32.
  - Clear busy and go to IDLE.
  - mem_req_valid is expected low in the RESP cycle, because the requester drops it combinationally on the response.
  - mem_req_valid high in the first IDLE cycle after RESP is a new request.
- Latency:
  - Valid-rise cycle T, capture at T+1, mem_rsp_valid at T+1+LATENCY.
  - LATENCY=1: capture at T+1, access at T+1, response at T+2.
- mem_rsp_load_data holds its last value until the next response.
- Only one request is outstanding at a time; there is no queuing.

Optional Feature:
- MEM_RSP_RANDOM_STALL_EN:
  - When defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every cycle.
  - In ARM, the counter is loaded with LATENCY-1 + lfsr[2:0], adding 0-7 extra cycles, to stress requester arbitration.
- Undefined: the latency is exactly LATENCY and no LFSR exists.

Test Plan:
- Store then load, LATENCY=4:
  - store addr 0x100, data 128'hDEAD...BEEF → mem_rsp_valid at valid-rise+5, echo data, store_count=1.
  - load 0x100 → same data, load_count=1.
- Alias: store to 0x100, load 0x4100 (LG_DEPTH=10, 16-byte lines) → returns the stored line. A load from 0x10F returns the same line.
- Valid pulses for only one cycle (drops in ARM) → no response, busy stays 0, counters unchanged.
- Bad opcode 4'd2 → response with data 0, bad_opcode=1 and sticky; a following valid load still succeeds.
- Back-to-back: new request raised in the cycle after RESP → accepted, second response at its own valid-rise+5, no lost or duplicate pulse.
- Async reset asserted during WAIT of a store → outputs cleared immediately, no response, and a subsequent load of that address returns the prior contents.

Source files
------------

// File: rtl/mem_cl_responder_if.sv
// Cache-line memory port between requester (master) and responder (slave).
// Request: valid/addr/store_data/opcode. Response: one-cycle valid + line data.
interface mem_cl_responder_if #(
  parameter int ADDR_W  = 32,
  parameter int CL_BITS = 128
);
  logic               mem_req_valid;
  logic [ADDR_W-1:0]  mem_req_addr;
  logic [CL_BITS-1:0] mem_req_store_data;
  logic [3:0]         mem_req_opcode;
  logic               mem_rsp_valid;
  logic [CL_BITS-1:0] mem_rsp_load_data;

  modport master (
    output mem_req_valid,
    output mem_req_addr,
    output mem_req_store_data,
    output mem_req_opcode,
    input  mem_rsp_valid,
    input  mem_rsp_load_data
  );

  modport slave (
    input  mem_req_valid,
    input  mem_req_addr,
    input  mem_req_store_data,
    input  mem_req_opcode,
    output mem_rsp_valid,
    output mem_rsp_load_data
  );
endinterface

// File: rtl/mem_cl_responder.sv
// Memory-side cache-line responder: one outstanding load/store served from
// an on-chip line array after LATENCY cycles, single-cycle response pulse.
// Ports: clk, reset (async, active-high), mem (slave side of the line port),
// busy, bad_opcode (sticky), load_count, store_count.
// Optional: define MEM_RSP_RANDOM_STALL_EN to add 0-7 LFSR-driven stall cycles.
module mem_cl_responder #(
  parameter int         ADDR_W      = 32,
  parameter int         LG_CL_BYTES = 4,
  parameter int         LG_DEPTH    = 10,
  parameter int         LATENCY     = 4,
  parameter logic [3:0] OPC_LOAD    = 4'd4,
  parameter logic [3:0] OPC_STORE   = 4'd7
) (
  input  logic        clk,
  input  logic        reset,
  mem_cl_responder_if.slave mem,
  output logic        busy,
  output logic        bad_opcode,
  output logic [31:0] load_count,
  output logic [31:0] store_count
);

  localparam int CL_BITS = 8 << LG_CL_BYTES;
  localparam int DEPTH   = 1 << LG_DEPTH;
  localparam int CNT_W   = $clog2(LATENCY + 8) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_WAIT,
    S_RESP
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    lat_ld;
  logic [LG_DEPTH-1:0] idx_q, idx_d;
  logic [3:0]          opc_q, opc_d;
  logic [CL_BITS-1:0]  sdata_q, sdata_d;
  logic [CL_BITS-1:0]  rdata_q, rdata_d;
  logic                bad_q, bad_d;
  logic [31:0]         lc_q, lc_d;
  logic [31:0]         sc_q, sc_d;

  logic                acc_en;
  logic [LG_DEPTH-1:0] acc_idx;
  logic [3:0]          acc_opc;
  logic [CL_BITS-1:0]  acc_data;
  logic                wr_en;
  logic [2:0]          extra;
  logic [LG_DEPTH-1:0] req_idx;
  logic                unused_addr;

  logic [CL_BITS-1:0]  mem_q [DEPTH];

  // Upper bits alias, low bits select a byte within the line.
  assign req_idx     = mem.mem_req_addr[LG_CL_BYTES +: LG_DEPTH];
  assign unused_addr = ^mem.mem_req_addr;

`ifdef MEM_RSP_RANDOM_STALL_EN
  logic [15:0] lfsr_q;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13]
                 ^ lfsr_q[12] ^ lfsr_q[10];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_fb};
    end
  end

  assign extra = lfsr_q[2:0];
`else
  assign extra = 3'd0;
`endif

  assign lat_ld = CNT_W'(LATENCY - 1) + CNT_W'(extra);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    opc_d    = opc_q;
    sdata_d  = sdata_q;
    lc_d     = lc_q;
    sc_d     = sc_q;
    acc_en   = 1'b0;
    acc_idx  = idx_q;
    acc_opc  = opc_q;
    acc_data = sdata_q;

    unique case (state_q)
      S_IDLE: begin
        // Fields are still settling here; sample them in ARM.
        if (mem.mem_req_valid) begin
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        if (mem.mem_req_valid) begin
          idx_d   = req_idx;
          opc_d   = mem.mem_req_opcode;
          sdata_d = mem.mem_req_store_data;
          cnt_d   = lat_ld;
          if (lat_ld == '0) begin
            // Zero wait cycles: access straight from the request.
            acc_en   = 1'b1;
            acc_idx  = req_idx;
            acc_opc  = mem.mem_req_opcode;
            acc_data = mem.mem_req_store_data;
            state_d  = S_RESP;
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_d == '0) begin
          acc_en  = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (opc_q == OPC_LOAD) begin
          lc_d = lc_q + 32'd1;
        end
        if (opc_q == OPC_STORE) begin
          sc_d = sc_q + 32'd1;
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    bad_d   = bad_q;
    wr_en   = 1'b0;
    if (acc_en) begin
      unique case (1'b1)
        (acc_opc == OPC_LOAD): begin
          rdata_d = mem_q[acc_idx];
        end
        (acc_opc == OPC_STORE): begin
          rdata_d = acc_data;
          wr_en   = 1'b1;
        end
        default: begin
          rdata_d = '0;
          bad_d   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      opc_q   <= '0;
      sdata_q <= '0;
      rdata_q <= '0;
      bad_q   <= 1'b0;
      lc_q    <= '0;
      sc_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      opc_q   <= opc_d;
      sdata_q <= sdata_d;
      rdata_q <= rdata_d;
      bad_q   <= bad_d;
      lc_q    <= lc_d;
      sc_q    <= sc_d;
    end
  end

  // Backing array is never reset; wr_en is gated by state, so a
  // request dropped by reset never writes.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[acc_idx] <= acc_data;
    end
  end

  assign mem.mem_rsp_valid     = (state_q == S_RESP);
  assign mem.mem_rsp_load_data = rdata_q;
  assign busy        = (state_q == S_WAIT) || (state_q == S_RESP);
  assign bad_opcode  = bad_q;
  assign load_count  = lc_q;
  assign store_count = sc_q;

endmodule
